bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the 8-bit-data / 16-bit-address memory bus. Master 0 is the CPU and master 1 is a secondary requester (DMA or debug port). The arbiter grants one master at a time, carries one whole transaction to the slave (memory/peripheral decode), returns read data plus a one-cycle done pulse, and enforces a slave timeout. Arbitration is round-robin with a registered grant; the CPU wins the first tie after reset.

---
 rtl/bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin arbiter for the 8-bit data /
// 16-bit address memory bus. One transaction in flight at a time, registered
// outputs throughout, sticky timeout flag.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic [7:0]  m0_rdata,
  output logic        m0_done,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic [7:0]  m1_rdata,
  output logic        m1_done,
  output logic [15:0] s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_read,
  output logic        s_write,
  input  logic [7:0]  s_rdata,
  input  logic        s_done,
  output logic        timeout_err,
  output logic        grant
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        terr_q, terr_d;

  logic        req0, req1, pick, finish;
  logic [7:0]  rdv;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      terr_q   <= terr_d;
    end
  end

  // Next-state logic: arbitration in IDLE, slave wait/timeout in ACTIVE,
  // one-cycle completion pulse in DONE.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    terr_d   = terr_q;
    pick     = 1'b0;
    finish   = 1'b0;
    rdv      = 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // Single requester: req1 selects it directly; tie: not the last one.
          pick    = (req0 && req1) ? ~last_q : req1;
          grant_d = pick;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          wr_d    = pick ? m1_write : m0_write;
          rd_d    = ~(pick ? m1_write : m0_write);
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (s_done) begin
          finish = 1'b1;
          rdv    = s_rdata;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          finish = 1'b1;
          rdv    = 8'hFF;
          terr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (finish) begin
          // wr_q still holds the latched op here; it is cleared with the strobes.
          if (!wr_q) begin
            if (grant_q) rdata1_d = rdv;
            else         rdata0_d = rdv;
          end
          done0_d = ~grant_q;
          done1_d = grant_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_read      = rd_q;
  assign s_write     = wr_q;
  assign m0_done     = done0_q;
  assign m1_done     = done1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign timeout_err = terr_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: transaction-level reference model (per-master request queues,
// round-robin pick, expected read data and sticky timeout) driven by directed
// and $urandom stimulus.
module tb_bus_arbiter;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_addr, m1_addr, s_addr;
  logic [7:0]  m0_wdata, m1_wdata, s_wdata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [7:0]  m0_rdata, m1_rdata, s_rdata;
  logic        m0_done, m1_done, s_read, s_write, s_done;
  logic        timeout_err, grant;

  bus_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
    .s_rdata(s_rdata), .s_done(s_done),
    .timeout_err(timeout_err), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
  } req_t;

  req_t       q0[$];
  req_t       q1[$];
  logic       last_m;
  logic [7:0] rd_m0, rd_m1;
  logic       terr_m;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk_req(input logic [15:0] a, input logic [7:0] d,
                                  input logic rd, input logic wr);
    req_t r;
    r.addr = a; r.wdata = d; r.rd = rd; r.wr = wr;
    return r;
  endfunction

  function automatic req_t rand_req();
    int unsigned k;
    k = $urandom_range(0, 2);
    return mk_req(16'($urandom), 8'($urandom), k != 1, k != 0);
  endfunction

  task automatic model_reset();
    last_m = 1'b1; rd_m0 = '0; rd_m1 = '0; terr_m = 1'b0;
  endtask

  task automatic drive_masters();
    if (q0.size() > 0) begin
      m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; m0_read = q0[0].rd; m0_write = q0[0].wr;
    end else begin
      m0_addr = 16'($urandom); m0_wdata = 8'($urandom); m0_read = 1'b0; m0_write = 1'b0;
    end
    if (q1.size() > 0) begin
      m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; m1_read = q1[0].rd; m1_write = q1[0].wr;
    end else begin
      m1_addr = 16'($urandom); m1_wdata = 8'($urandom); m1_read = 1'b0; m1_write = 1'b0;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".s_read"},  s_read,  1'b0);
    check({tag, ".s_write"}, s_write, 1'b0);
    check({tag, ".m0_done"}, m0_done, 1'b0);
    check({tag, ".m1_done"}, m1_done, 1'b0);
    check({tag, ".terr"},    timeout_err, terr_m);
  endtask

  // One transaction: the slave asserts s_done in ACTIVE cycle w+1, or never
  // when that would fall past the timeout cycle T+1.
  task automatic serve(input int unsigned w, input bit drop_mid, input logic [7:0] sd);
    int   g, n;
    bit   tmo;
    logic wr_e;
    req_t r;
    if (q0.size() > 0 && q1.size() > 0) g = last_m ? 0 : 1;
    else if (q0.size() > 0)             g = 0;
    else                                g = 1;
    r    = (g == 0) ? q0[0] : q1[0];
    wr_e = r.wr;
    tmo  = (w >= T + 1);
    n    = tmo ? int'(T + 1) : int'(w + 1);
    tick();
    for (int c = 1; c <= n; c++) begin
      check("act.s_read",  s_read,  !wr_e);
      check("act.s_write", s_write, wr_e);
      check("act.s_addr",  s_addr,  r.addr);
      check("act.s_wdata", s_wdata, r.wdata);
      check("act.grant",   grant,   g[0]);
      check("act.m0_done", m0_done, 1'b0);
      check("act.m1_done", m1_done, 1'b0);
      s_done  = (c == int'(w + 1));
      s_rdata = sd;
      if (drop_mid && c == 1 && n > 1) begin
        if (g == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else        begin m1_read = 1'b0; m1_write = 1'b0; end
      end
      tick();
    end
    s_done  = 1'b0;
    s_rdata = 8'($urandom);
    if (!wr_e) begin
      if (g == 0) rd_m0 = tmo ? 8'hFF : sd;
      else        rd_m1 = tmo ? 8'hFF : sd;
    end
    if (tmo) terr_m = 1'b1;
    last_m = g[0];
    check("done.m0_done",  m0_done,  g == 0);
    check("done.m1_done",  m1_done,  g == 1);
    check("done.m0_rdata", m0_rdata, rd_m0);
    check("done.m1_rdata", m1_rdata, rd_m1);
    check("done.terr",     timeout_err, terr_m);
    check("done.s_read",   s_read,   1'b0);
    check("done.s_write",  s_write,  1'b0);
    if (g == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
    drive_masters();
    tick();
    check_quiet("idle");
    check("idle.grant", grant, g[0]);
  endtask

  task automatic run_queues(input bit rand_wait, input int unsigned w_fix);
    drive_masters();
    while (q0.size() > 0 || q1.size() > 0) begin
      if (rand_wait) serve($urandom_range(0, T + 2), $urandom_range(0, 5) == 0, 8'($urandom));
      else           serve(w_fix, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; s_done = 1'b0; s_rdata = '0;
    drive_masters();
    model_reset();
    tick(); tick();
    check("rst.s_addr",   s_addr,   16'h0);
    check("rst.s_wdata",  s_wdata,  8'h0);
    check("rst.m0_rdata", m0_rdata, 8'h0);
    check("rst.m1_rdata", m1_rdata, 8'h0);
    check("rst.grant",    grant,    1'b0);
    check_quiet("rst");
    rst = 1'b0;
    tick();
    check_quiet("post_rst");

    // Tie after reset: m0 then m1.
    q0.push_back(mk_req(16'h1000, 8'h00, 1'b1, 1'b0));
    q1.push_back(mk_req(16'h2000, 8'h00, 1'b1, 1'b0));
    drive_masters();
    serve(1, 1'b0, 8'h11);
    serve(0, 1'b0, 8'h22);

    // Single read with two wait cycles.
    q0.push_back(mk_req(16'h0001, 8'h00, 1'b1, 1'b0));
    drive_masters();
    serve(2, 1'b0, 8'h55);
    check("single.m0_rdata", m0_rdata, 8'h55);

    // Fairness: six writes each, zero-wait slave.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk_req(16'(16'h0100 + i), 8'(i), 1'b0, 1'b1));
      q1.push_back(mk_req(16'(16'h0200 + i), 8'(8'h80 + i), 1'b0, 1'b1));
    end
    run_queues(1'b0, 0);

    // Timeout on m1 read, then a good transaction keeps the flag.
    q1.push_back(mk_req(16'h3333, 8'h00, 1'b1, 1'b0));
    drive_masters();
    serve(T + 2, 1'b0, 8'h12);
    check("tmo.m1_rdata", m1_rdata, 8'hFF);
    check("tmo.terr",     timeout_err, 1'b1);
    q1.push_back(mk_req(16'h3334, 8'h00, 1'b1, 1'b0));
    drive_masters();
    serve(T, 1'b0, 8'h77);
    check("tmo.sticky", timeout_err, 1'b1);

    // Read+write together is a write; rdata unchanged.
    q0.push_back(mk_req(16'h4444, 8'hAA, 1'b1, 1'b1));
    drive_masters();
    serve(1, 1'b0, 8'h99);
    check("rw.m0_rdata", m0_rdata, 8'h55);

    // Randomized scenarios with idle gaps.
    for (int s = 0; s < 40; s++) begin
      int unsigned k0, k1, gap;
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      for (int i = 0; i < int'(k0); i++) q0.push_back(rand_req());
      for (int i = 0; i < int'(k1); i++) q1.push_back(rand_req());
      run_queues(1'b1, 0);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < int'(gap); i++) begin
        tick();
        check_quiet("gap");
      end
    end

    // Reset while ACTIVE: transaction dropped, no done, m0 wins next tie.
    q1.push_back(mk_req(16'h5555, 8'h00, 1'b1, 1'b0));
    drive_masters();
    tick();
    check("rmid.s_read", s_read, 1'b1);
    rst = 1'b1;
    tick();
    model_reset();
    q1.delete();
    check("rmid.grant",    grant,    1'b0);
    check("rmid.m1_rdata", m1_rdata, 8'h0);
    check_quiet("rmid");
    rst = 1'b0;
    drive_masters();
    tick();
    check_quiet("rmid_after");
    tick();
    check_quiet("rmid_after2");
    q0.push_back(mk_req(16'h6000, 8'h00, 1'b1, 1'b0));
    q1.push_back(mk_req(16'h7000, 8'h01, 1'b0, 1'b1));
    run_queues(1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
